instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Write-side companion to the byte-addressable instruction memory. It accepts a byte stream over a valid/ready handshake and converts it into sequential single-byte writes to the 256-byte instruction store, in the store's big-endian order. It holds the CPU off while loading and reports completion, byte count and a word-level XOR checksum. It sits between the boot/debug byte source and the instruction memory's write port.

## Interface
- MEM_BYTES, 256, instruction store size in bytes; must be a power of two
- ADDR_W, 8, byte address width; equals log2(MEM_BYTES)

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load; sampled in IDLE or DONE only
- base_addr  in  ADDR_W  first byte address; sampled with start
- len_words  in  ADDR_W-1  number of 32-bit instructions to load, legal range 1..MEM_BYTES/4; sampled with start
- abort  in  1  cancels a load in progress
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte_data this cycle
- mem_we  out  1  byte write strobe to instruction memory
- mem_addr  out  ADDR_W  byte write address
- mem_wdata  out  8  byte write data
- cpu_hold  out  1  keeps the CPU/PC stalled while high
- busy  out  1  high in LOAD and FLUSH
- done  out  1  level; load completed successfully
- error  out  1  level; last start was rejected
- checksum  out  32  XOR of all completed words in the current load

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE/DONE + start:
  - Reject when base_addr[1:0] != 0, len_words == 0, or len_words > MEM_BYTES/4. On reject, set error=1, stay in the current state, and leave done unchanged.
  - Otherwise, go to LOAD. Clear error, done and checksum. Load the byte counter with 4*len_words and the address register with base_addr.
- start while in LOAD or FLUSH has no effect.
- LOAD:
  - byte_ready=1.
  - Each handshake (byte_valid & byte_ready) registers one write. Address advances by 1 modulo MEM_BYTES. The byte counter decrements.
  - Bytes are shifted into a 32-bit assembly register, first byte in [31:24], matching the fetch order addr, +1, +2, +3.
  - On every 4th byte, checksum ^= assembled word.
  - When the final byte is accepted, go to FLUSH.
- FLUSH: one cycle. byte_ready=0. The last write is on the port. Then go to DONE.
- DONE: done=1, cpu_hold=0, byte_ready=0. Stays here until start.
- abort in LOAD or FLUSH: go to IDLE on the next edge. The pending registered write still completes, but no further writes occur. done=0, checksum is held, cpu_hold drops.
- Address wrap: base_addr + 4*len_words above MEM_BYTES wraps to address 0 and continues. No error is raised.
- The byte counter is ADDR_W+1 bits wide so that a full 256-byte load is representable.

## Timing
- Reset values:
  - state IDLE
  - byte_ready 0, mem_we 0, mem_addr 0, mem_wdata 0
  - cpu_hold 0, busy 0, done 0, error 0, checksum 0
- Write latency: a byte accepted at edge N drives mem_we/mem_addr/mem_wdata for the cycle after edge N. There is exactly one write per accepted byte, and mem_we is never asserted without a handshake.
- byte_ready rises the cycle after the accepting start edge and drops the cycle after the final byte is accepted.
- cpu_hold and busy rise together with byte_ready.
- done rises, and cpu_hold and busy fall, two edges after the final byte handshake (after FLUSH).
- checksum updates on the same edge as the 4th-byte handshake. It is final by FLUSH.
- Throughput is 1 byte per cycle when byte_valid is held high. Gaps in byte_valid stall the load without timeout.
- Reset mid-load forces all outputs to their reset values immediately. Bytes already written stay in memory.

## Structure
- Shared package:
  - state enum (IDLE, LOAD, FLUSH, DONE)
  - MEM_BYTES/ADDR_W defaults
  - WORD_BYTES=4 constant
- One natural sub-module, `byte_word_packer`: a shift register plus 2-bit phase counter that emits word_valid and word on every 4th byte. It feeds the checksum.
- No memory inside this block. Writes go to the instruction memory's byte write port.

## Test plan
- Basic load: base_addr=0x00, len_words=2, bytes 0x20,0x08,0x00,0x05,0x00,0x00,0x00,0x08 back-to-back.
  - Required: 8 writes at addr 0..7 with matching data.
  - Required: checksum=0x20080005^0x00000008=0x2008000D.
  - Required: done rises 2 cycles after the 8th handshake, cpu_hold falls in the same cycle.
- Wrap: base_addr=0xFC, len_words=2.
  - Required: writes land at 0xFC,0xFD,0xFE,0xFF,0x00,0x01,0x02,0x03.
  - Required: no error, done=1.
- Rejects, each from IDLE:
  - base_addr=0x02 → error=1, no writes, byte_ready stays 0.
  - len_words=0 → error=1, no writes, byte_ready stays 0.
  - len_words=65 → error=1, no writes, byte_ready stays 0.
  - A following legal start clears error.
- Stalls and ignored start: byte_valid toggled 1,0,0,1,... over a 1-word load.
  - Required: writes occur only after handshakes.
  - Required: a start pulse mid-LOAD is ignored and byte count stays 4.
- Abort: abort asserted after 5 of 8 bytes.
  - Required: exactly 5 writes occur, next state IDLE, done=0, cpu_hold=0.
  - Required: a new start works normally.
- Async reset mid-LOAD after 3 bytes.
  - Required: all outputs reach reset values without waiting for a clock edge.
  - Required: after reset_n release, a full 64-word load from 0x00 completes with 256 writes and done=1.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and sizing for the instruction-memory byte loader.
package instr_mem_loader_pkg;

    localparam int unsigned MEM_BYTES  = 256;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StDone
    } state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and byte write port of the loader, grouped as one bundle.
interface instr_mem_loader_if
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned AddrW = ADDR_W
) ();

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             mem_we;
    logic [AddrW-1:0] mem_addr;
    logic [7:0]       mem_wdata;

    // master: the loader itself; slave: byte source plus instruction memory side
    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/byte_word_packer.sv
// Packs a byte stream into big-endian 32-bit words; flags every 4th byte.
module byte_word_packer
    import instr_mem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  phase_q, phase_d;

    always_comb begin
        shift_d = shift_q;
        phase_d = phase_q;
        if (clr_i) begin
            shift_d = '0;
            phase_d = '0;
        end else if (in_valid_i) begin
            shift_d = {shift_q[15:0], in_byte_i};
            phase_d = phase_q + 2'd1;
        end
    end

    // Word is complete in the same cycle the 4th byte is presented.
    assign word_o       = {shift_q, in_byte_i};
    assign word_valid_o = in_valid_i && (phase_q == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            phase_q <= '0;
        end else begin
            shift_q <= shift_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Converts a byte stream into sequential byte writes to the instruction store,
// stalling the CPU during the load and accumulating a word-level XOR checksum.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned MemBytes = MEM_BYTES,
    parameter int unsigned AddrW    = ADDR_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrW-1:0]     base_addr_i,
    input  logic [AddrW-2:0]     len_words_i,
    input  logic                 abort_i,
    instr_mem_loader_if.master   bus,
    output logic                 cpu_hold_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [31:0]          checksum_o
);

    localparam logic [AddrW-2:0] MaxWords = (AddrW-1)'(MemBytes / WORD_BYTES);

    state_e           state_q, state_d;
    logic [AddrW:0]   cnt_q, cnt_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic             we_q, we_d;
    logic [AddrW-1:0] waddr_q, waddr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             error_q, error_d;
    logic [31:0]      checksum_q, checksum_d;
    logic             hs, start_ok, pack_clr, word_valid;
    logic [31:0]      word;

    // Abort masks ready so no byte is taken in the cycle the load is cancelled.
    assign bus.byte_ready = (state_q == StLoad) && !abort_i;
    assign hs             = bus.byte_valid && bus.byte_ready;
    assign start_ok       = (base_addr_i[1:0] == 2'b00) && (len_words_i != '0) &&
                            (len_words_i <= MaxWords);

    byte_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (pack_clr),
        .in_valid_i   (hs),
        .in_byte_i    (bus.byte_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = hs;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
        checksum_d = checksum_q;
        pack_clr   = 1'b0;

        if (hs) begin
            waddr_d = addr_q;
            wdata_d = bus.byte_data;
        end
        if (word_valid) begin
            checksum_d = checksum_q ^ word;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    if (start_ok) begin
                        state_d    = StLoad;
                        error_d    = 1'b0;
                        checksum_d = '0;
                        cnt_d      = {len_words_i, 2'b00};
                        addr_d     = base_addr_i;
                        pack_clr   = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (hs) begin
                    addr_d = addr_q + AddrW'(1);
                    cnt_d  = cnt_q - (AddrW+1)'(1);
                    if (cnt_q == (AddrW+1)'(1)) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: state_d = abort_i ? StIdle : StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            error_q    <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
            checksum_q <= checksum_d;
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy_o        = (state_q == StLoad) || (state_q == StFlush);
    assign cpu_hold_o    = busy_o;
    assign done_o        = (state_q == StDone);
    assign error_o       = error_q;
    assign checksum_o    = checksum_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader with a write-port recorder.
module tb_instr_mem_loader;
    import instr_mem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  base = '0;
    logic [6:0]  len = '0;
    logic        cpu_hold, busy, done, error;
    logic [31:0] checksum;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_b [256];
    logic [7:0]  wa [$];
    logic [7:0]  wd [$];
    logic [31:0] exp_cs;

    instr_mem_loader_if #(.AddrW(ADDR_W)) bus ();

    instr_mem_loader dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .base_addr_i (base),
        .len_words_i (len),
        .abort_i     (abort),
        .bus         (bus),
        .cpu_hold_o  (cpu_hold),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error),
        .checksum_o  (checksum)
    );

    always #5 clk = ~clk;

    // Memory-side recorder: a write is whatever is on the port at the rising edge.
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] b, input logic [6:0] l);
        start = 1'b1;
        base  = b;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = exp_b[i];
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic verify(input string tag, input logic [7:0] base_a, input int n);
        int         bad;
        logic [7:0] ea;
        bad = 0;
        chk({tag, "_count"}, 32'(wa.size()), 32'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
            ea = base_a + 8'(i);
            if (wa[i] !== ea || wd[i] !== exp_b[i]) bad++;
        end
        chk({tag, "_data"}, 32'(bad), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_checksum"}, checksum, 32'd0);
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Rejected starts from IDLE
        do_start(8'h02, 7'd2);
        chk("rej_base_error", 32'(error), 32'd1);
        chk("rej_base_ready", 32'(bus.byte_ready), 32'd0);
        do_start(8'h00, 7'd0);
        chk("rej_len0_error", 32'(error), 32'd1);
        chk("rej_len0_ready", 32'(bus.byte_ready), 32'd0);
        do_start(8'h00, 7'd65);
        chk("rej_len65_error", 32'(error), 32'd1);
        chk("rej_len65_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rej_writes", 32'(wa.size()), 32'd0);

        // Basic two-word load
        exp_b[0] = 8'h20; exp_b[1] = 8'h08; exp_b[2] = 8'h00; exp_b[3] = 8'h05;
        exp_b[4] = 8'h00; exp_b[5] = 8'h00; exp_b[6] = 8'h00; exp_b[7] = 8'h08;
        do_start(8'h00, 7'd2);
        chk("basic_error_cleared", 32'(error), 32'd0);
        chk("basic_ready", 32'(bus.byte_ready), 32'd1);
        chk("basic_hold", 32'(cpu_hold), 32'd1);
        send_bytes(8);
        chk("basic_flush_ready", 32'(bus.byte_ready), 32'd0);
        chk("basic_flush_done", 32'(done), 32'd0);
        chk("basic_flush_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_hold_drop", 32'(cpu_hold), 32'd0);
        chk("basic_busy_drop", 32'(busy), 32'd0);
        chk("basic_checksum", checksum, 32'h2008000D);
        verify("basic", 8'h00, 8);

        // Address wrap from DONE
        wa.delete(); wd.delete();
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        exp_b[4] = 8'h55; exp_b[5] = 8'h66; exp_b[6] = 8'h77; exp_b[7] = 8'h88;
        do_start(8'hFC, 7'd2);
        chk("wrap_done_cleared", 32'(done), 32'd0);
        send_bytes(8);
        @(negedge clk);
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_error", 32'(error), 32'd0);
        chk("wrap_checksum", checksum, 32'h444444CC);
        verify("wrap", 8'hFC, 8);

        // Stalled source and an ignored mid-load start
        wa.delete(); wd.delete();
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
        do_start(8'h20, 7'd1);
        for (int i = 0; i < 4; i++) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = exp_b[i];
            @(negedge clk);
            bus.byte_valid = 1'b0;
            if (i < 3) begin
                if (i == 1) begin
                    start = 1'b1;
                    base  = 8'h40;
                    len   = 7'd3;
                end
                @(negedge clk);
                start = 1'b0;
                if (i == 0) chk("stall_one_write", 32'(wa.size()), 32'd1);
                @(negedge clk);
                if (i == 0) chk("stall_no_extra", 32'(wa.size()), 32'd1);
            end
        end
        @(negedge clk);
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_checksum", checksum, 32'hDEADBEEF);
        verify("stall", 8'h20, 4);

        // Abort after 5 of 8 bytes
        wa.delete(); wd.delete();
        for (int i = 0; i < 8; i++) exp_b[i] = 8'(i + 1);
        do_start(8'h80, 7'd2);
        send_bytes(5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hold", 32'(cpu_hold), 32'd0);
        chk("abort_ready", 32'(bus.byte_ready), 32'd0);
        chk("abort_checksum_held", checksum, 32'h01020304);
        @(negedge clk);
        verify("abort", 8'h80, 5);

        wa.delete(); wd.delete();
        exp_b[0] = 8'hCA; exp_b[1] = 8'hFE; exp_b[2] = 8'hBA; exp_b[3] = 8'hBE;
        do_start(8'h00, 7'd1);
        send_bytes(4);
        @(negedge clk);
        chk("post_abort_done", 32'(done), 32'd1);
        chk("post_abort_checksum", checksum, 32'hCAFEBABE);
        verify("post_abort", 8'h00, 4);

        // Asynchronous reset mid-load, then a full-store load
        for (int i = 0; i < 4; i++) exp_b[i] = 8'(8'h31 + i);
        do_start(8'h10, 7'd1);
        send_bytes(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        wa.delete(); wd.delete();
        exp_cs = '0;
        for (int i = 0; i < 256; i++) exp_b[i] = 8'(i * 7 + 3);
        for (int w = 0; w < 64; w++) begin
            exp_cs = exp_cs ^ {exp_b[4*w], exp_b[4*w+1], exp_b[4*w+2], exp_b[4*w+3]};
        end
        do_start(8'h00, 7'd64);
        send_bytes(256);
        @(negedge clk);
        chk("full_done", 32'(done), 32'd1);
        chk("full_checksum", checksum, exp_cs);
        verify("full", 8'h00, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
